// File: rtl/psum_buffer_responder.sv
// psum_buffer_responder
//
// Responder side of the partial-sum buffer link used by the convolution main
// controller. A DEPTH-entry scratchpad accumulates PE partial sums at a write
// pointer. Read requests are served with a registered fetch and a one-cycle
// valid pulse. The fetched psum is then pushed into the output write buffer,
// and a completion code is returned to the controller.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous active-low reset
//   global_rst        synchronous clear; has priority over every other input
//   psum_in           partial sum from the PE
//   psum_wr           write/accumulate psum_in at waddr
//   first_time        with psum_wr: overwrite instead of accumulate
//   next_psum_waddr   advance waddr (wraps)
//   next_psum_raddr   advance raddr (wraps)
//   rst_psum_raddr    raddr <= 0, has priority over next_psum_raddr
//   psum_buffer_ren   read request, honoured only in S_IDLE
//   wb_full           output write buffer back-pressure
//   can_read_psum     entry at raddr holds data and the FSM is idle
//   psum_buffer_valid one-cycle pulse: psum_rdata is valid
//   psum_rdata        registered read data
//   psum_w_co         write pointer carry-out (advance from DEPTH-1)
//   stall             completion code: 00 busy, 10 more data, 11 drained
//   wb_wen            write strobe to the output write buffer
//   wb_wdata          data for the output write buffer (psum_rdata)
//
// DEPTH must be a power of two so that the pointers wrap by overflow.
module psum_buffer_responder #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  global_rst,
    input  logic [DATA_WIDTH-1:0] psum_in,
    input  logic                  psum_wr,
    input  logic                  first_time,
    input  logic                  next_psum_waddr,
    input  logic                  next_psum_raddr,
    input  logic                  rst_psum_raddr,
    input  logic                  psum_buffer_ren,
    input  logic                  wb_full,
    output logic                  can_read_psum,
    output logic                  psum_buffer_valid,
    output logic [DATA_WIDTH-1:0] psum_rdata,
    output logic                  psum_w_co,
    output logic [1:0]            stall,
    output logic                  wb_wen,
    output logic [DATA_WIDTH-1:0] wb_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_VALID,
        S_HOLD,
        S_PUSH,
        S_RESP
    } state_t;

    state_t                state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH-1:0] ridx_p0;
    logic [DATA_WIDTH-1:0] rdata_p1;

    logic accept;
    logic push;
    logic inc;
    logic dec;

    // Two's-complement accumulation; the sum wraps modulo 2^DATA_WIDTH.
    function automatic logic signed [DATA_WIDTH-1:0] acc_wrap(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return a + b;
    endfunction

    assign can_read_psum = valid[raddr] && (state == S_IDLE);
    assign psum_w_co     = next_psum_waddr && (waddr == ADDR_WIDTH'(DEPTH - 1));
    assign psum_rdata    = rdata_p1;
    assign wb_wdata      = rdata_p1;

    // A write that lands on an empty entry adds one to the occupancy. A push
    // removes one, unless a write re-fills the entry being pushed in the same
    // cycle: that write keeps the entry valid, so the occupancy stays put.
    assign inc = psum_wr && !valid[waddr];
    assign dec = push && !(psum_wr && (waddr == ridx_p0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else if (global_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        accept            = 1'b0;
        push              = 1'b0;
        psum_buffer_valid = 1'b0;
        wb_wen            = 1'b0;
        stall             = 2'b00;
        case (state)
            S_IDLE: begin
                if (psum_buffer_ren && can_read_psum) begin
                    accept    = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                state_nxt = S_VALID;
            end
            S_VALID: begin
                psum_buffer_valid = 1'b1;
                state_nxt         = wb_full ? S_HOLD : S_PUSH;
            end
            S_HOLD: begin
                if (!wb_full) begin
                    state_nxt = S_PUSH;
                end
            end
            S_PUSH: begin
                wb_wen    = 1'b1;
                push      = 1'b1;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                // count already reflects the push of the previous cycle
                stall     = (count != '0) ? 2'b10 : 2'b11;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Scratchpad storage: no reset, contents are undefined until written.
    always_ff @(posedge clk) begin
        if (psum_wr && !global_rst) begin
            mem[waddr] <= first_time ? psum_in : acc_wrap(mem[waddr], psum_in);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waddr    <= '0;
            raddr    <= '0;
            valid    <= '0;
            count    <= '0;
            ridx_p0  <= '0;
            rdata_p1 <= '0;
        end else if (global_rst) begin
            waddr    <= '0;
            raddr    <= '0;
            valid    <= '0;
            count    <= '0;
            ridx_p0  <= '0;
            rdata_p1 <= '0;
        end else begin
            if (next_psum_waddr) begin
                waddr <= waddr + ADDR_WIDTH'(1);
            end

            if (rst_psum_raddr) begin
                raddr <= '0;
            end else if (next_psum_raddr) begin
                raddr <= raddr + ADDR_WIDTH'(1);
            end

            // stage p0: capture the entry index when a request is accepted
            if (accept) begin
                ridx_p0 <= raddr;
            end

            // stage p1: fetch; a same-cycle write to ridx is not yet visible
            if (state == S_READ) begin
                rdata_p1 <= mem[ridx_p0];
            end

            // the set is issued last so a coincident write keeps the entry valid
            if (push) begin
                valid[ridx_p0] <= 1'b0;
            end
            if (psum_wr) begin
                valid[waddr] <= 1'b1;
            end

            if (inc && !dec) begin
                count <= count + (ADDR_WIDTH + 1)'(1);
            end else if (dec && !inc) begin
                count <= count - (ADDR_WIDTH + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_psum_buffer_responder.sv
module tb_psum_buffer_responder;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          global_rst;
    logic [DW-1:0] psum_in;
    logic          psum_wr;
    logic          first_time;
    logic          next_psum_waddr;
    logic          next_psum_raddr;
    logic          rst_psum_raddr;
    logic          psum_buffer_ren;
    logic          wb_full;
    logic          can_read_psum;
    logic          psum_buffer_valid;
    logic [DW-1:0] psum_rdata;
    logic          psum_w_co;
    logic [1:0]    stall;
    logic          wb_wen;
    logic [DW-1:0] wb_wdata;

    int checks   = 0;
    int failures = 0;

    // behavioural model of the scratchpad
    logic [DW-1:0] mem_m [DEPTH];
    bit            vld_m [DEPTH];
    int            waddr_m;
    int            raddr_m;

    typedef struct {
        logic          wr;
        logic          ft;
        logic [DW-1:0] din;
        logic          nwa;
        logic          nra;
        logic          rra;
        logic          exp_co;
        logic          exp_crd;
    } vec_t;

    vec_t tbl [17];

    always #5 clk = ~clk;

    psum_buffer_responder #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .global_rst       (global_rst),
        .psum_in          (psum_in),
        .psum_wr          (psum_wr),
        .first_time       (first_time),
        .next_psum_waddr  (next_psum_waddr),
        .next_psum_raddr  (next_psum_raddr),
        .rst_psum_raddr   (rst_psum_raddr),
        .psum_buffer_ren  (psum_buffer_ren),
        .wb_full          (wb_full),
        .can_read_psum    (can_read_psum),
        .psum_buffer_valid(psum_buffer_valid),
        .psum_rdata       (psum_rdata),
        .psum_w_co        (psum_w_co),
        .stall            (stall),
        .wb_wen           (wb_wen),
        .wb_wdata         (wb_wdata)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    function automatic int pop();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += vld_m[i] ? 1 : 0;
        return n;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) vld_m[i] = 1'b0;
        waddr_m = 0;
        raddr_m = 0;
    endfunction

    function automatic void model_write(int a, logic ft, logic [DW-1:0] d);
        logic [DW-1:0] s;
        s        = mem_m[a] + d;
        mem_m[a] = ft ? d : s;
        vld_m[a] = 1'b1;
    endfunction

    task automatic clr_in();
        global_rst      = 1'b0;
        psum_in         = '0;
        psum_wr         = 1'b0;
        first_time      = 1'b0;
        next_psum_waddr = 1'b0;
        next_psum_raddr = 1'b0;
        rst_psum_raddr  = 1'b0;
        psum_buffer_ren = 1'b0;
        wb_full         = 1'b0;
    endtask

    task automatic drive_in(logic wr, logic ft, logic [DW-1:0] din,
                            logic nwa, logic nra, logic rra);
        psum_wr         = wr;
        first_time      = ft;
        psum_in         = din;
        next_psum_waddr = nwa;
        next_psum_raddr = nra;
        rst_psum_raddr  = rra;
        #1;
    endtask

    task automatic chk_idle(string nm);
        chk({nm, " can_read"}, can_read_psum, vld_m[raddr_m]);
        chk({nm, " w_co"}, psum_w_co, next_psum_waddr && (waddr_m == DEPTH - 1));
        chk({nm, " valid"}, psum_buffer_valid, 1'b0);
        chk({nm, " wb_wen"}, wb_wen, 1'b0);
        chk({nm, " stall"}, stall, 2'b00);
    endtask

    task automatic edge_update();
        @(posedge clk); #1;
        if (psum_wr) model_write(waddr_m, first_time, psum_in);
        if (next_psum_waddr) waddr_m = (waddr_m + 1) % DEPTH;
        if (rst_psum_raddr) raddr_m = 0;
        else if (next_psum_raddr) raddr_m = (raddr_m + 1) % DEPTH;
        clr_in();
    endtask

    task automatic step(logic wr, logic ft, logic [DW-1:0] din,
                        logic nwa, logic nra, logic rra, string nm);
        drive_in(wr, ft, din, nwa, nra, rra);
        chk_idle(nm);
        edge_update();
    endtask

    task automatic hw_reset();
        clr_in();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
    endtask

    // One full read transaction. wr_phase: 0 none, 1 write during S_READ,
    // 2 write during S_PUSH (always at the current write pointer).
    task automatic do_read(int hold, int wr_phase, logic ft, logic [DW-1:0] wd, string nm);
        int            r;
        int            w;
        logic [DW-1:0] exp_d;
        logic [1:0]    exp_st;
        r     = raddr_m;
        w     = waddr_m;
        exp_d = mem_m[r];
        clr_in();
        psum_buffer_ren = 1'b1;
        #1;
        chk({nm, " accept can_read"}, can_read_psum, vld_m[r]);
        @(posedge clk); #1;
        // S_READ, request still held: must not be re-accepted
        if (wr_phase == 1) begin
            psum_wr = 1'b1; first_time = ft; psum_in = wd;
        end
        #1;
        chk({nm, " read valid"}, psum_buffer_valid, 1'b0);
        chk({nm, " read can_read"}, can_read_psum, 1'b0);
        chk({nm, " read wb_wen"}, wb_wen, 1'b0);
        @(posedge clk); #1;
        if (wr_phase == 1) model_write(w, ft, wd);
        psum_wr = 1'b0; first_time = 1'b0; psum_in = '0;
        chk({nm, " pulse valid"}, psum_buffer_valid, 1'b1);
        chk({nm, " rdata"}, psum_rdata, exp_d);
        chk({nm, " pulse wb_wen"}, wb_wen, 1'b0);
        chk({nm, " pulse stall"}, stall, 2'b00);
        for (int i = 0; i < hold; i++) begin
            wb_full = 1'b1;
            @(posedge clk); #1;
            chk({nm, " hold wb_wen"}, wb_wen, 1'b0);
            chk({nm, " hold valid"}, psum_buffer_valid, 1'b0);
            chk({nm, " hold stall"}, stall, 2'b00);
        end
        wb_full = 1'b0;
        @(posedge clk); #1;
        chk({nm, " push wb_wen"}, wb_wen, 1'b1);
        chk({nm, " push wdata"}, wb_wdata, exp_d);
        chk({nm, " push stall"}, stall, 2'b00);
        psum_buffer_ren = 1'b0;
        if (wr_phase == 2) begin
            psum_wr = 1'b1; first_time = ft; psum_in = wd;
        end
        @(posedge clk); #1;
        vld_m[r] = 1'b0;
        if (wr_phase == 2) model_write(w, ft, wd);
        clr_in();
        exp_st = (pop() != 0) ? 2'b10 : 2'b11;
        chk({nm, " resp stall"}, stall, exp_st);
        chk({nm, " resp wb_wen"}, wb_wen, 1'b0);
        @(posedge clk); #1;
        chk({nm, " idle stall"}, stall, 2'b00);
    endtask

    task automatic chk_quiet(string nm);
        chk({nm, " valid"}, psum_buffer_valid, 1'b0);
        chk({nm, " wb_wen"}, wb_wen, 1'b0);
        chk({nm, " stall"}, stall, 2'b00);
        chk({nm, " rdata"}, psum_rdata, '0);
        chk({nm, " can_read"}, can_read_psum, 1'b0);
    endtask

    // Start a read and park the FSM in S_HOLD with wb_full asserted.
    task automatic park_in_hold(string nm);
        step(1'b1, 1'b1, 16'h00AB, 1'b0, 1'b0, 1'b0, {nm, " fill"});
        psum_buffer_ren = 1'b1;
        @(posedge clk); #1;
        psum_buffer_ren = 1'b0;
        @(posedge clk); #1;
        chk({nm, " pre-abort valid"}, psum_buffer_valid, 1'b1);
        wb_full = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk({nm, " hold wb_wen"}, wb_wen, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        //              wr    ft    din       nwa   nra   rra   co    crd
        tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // reset state
        #2;
        chk_quiet("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // pointer wrap, carry-out and read-pointer priority
        for (int i = 0; i < 17; i++) begin
            drive_in(tbl[i].wr, tbl[i].ft, tbl[i].din, tbl[i].nwa, tbl[i].nra, tbl[i].rra);
            chk($sformatf("tbl%0d w_co", i), psum_w_co, tbl[i].exp_co);
            chk($sformatf("tbl%0d can_read", i), can_read_psum, tbl[i].exp_crd);
            chk_idle($sformatf("tbl%0d", i));
            edge_update();
        end
        do_read(0, 0, 1'b0, '0, "tbl_read");
        chk("tbl_read stall data", psum_rdata, 16'h0007);

        // accumulate with wrap
        hw_reset();
        step(1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, "acc w0");
        step(1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, "acc w1");
        do_read(0, 0, 1'b0, '0, "acc");
        chk("acc rdata const", psum_rdata, 16'h0002);

        // handshake with two valid entries: 10 then 11
        hw_reset();
        step(1'b1, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, "hs w0");
        step(1'b1, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b0, "hs w1");
        do_read(0, 0, 1'b0, '0, "hs r0");
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, "hs nra");
        do_read(0, 0, 1'b0, '0, "hs r1");
        chk("hs r1 data const", psum_rdata, 16'h0020);

        // back-pressure for three cycles
        hw_reset();
        step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, "bp w");
        do_read(3, 0, 1'b0, '0, "bp");

        // write to ridx during S_READ, then during S_PUSH
        hw_reset();
        step(1'b1, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0, "col w");
        do_read(0, 1, 1'b1, 16'h0022, "col read");
        chk("col read old data", psum_rdata, 16'h0009);
        step(1'b1, 1'b1, 16'h0033, 1'b0, 1'b0, 1'b0, "col w2");
        do_read(1, 2, 1'b0, 16'h0001, "col push");
        do_read(0, 0, 1'b0, '0, "col after");
        chk("col after data", psum_rdata, 16'h0034);

        // asynchronous reset in S_HOLD
        hw_reset();
        park_in_hold("abort");
        reset = 1'b0;
        #1;
        chk_quiet("abort during");
        @(posedge clk); #1;
        reset = 1'b1;
        wb_full = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk_quiet($sformatf("abort after%0d", i));
        end
        step(1'b1, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b0, "abort w");
        do_read(0, 0, 1'b0, '0, "abort read");

        // synchronous clear in S_HOLD, overriding a concurrent write
        hw_reset();
        park_in_hold("gabort");
        global_rst = 1'b1;
        psum_wr = 1'b1; first_time = 1'b1; psum_in = 16'h5555; next_psum_waddr = 1'b1;
        @(posedge clk); #1;
        clr_in();
        model_reset();
        #1;
        chk_quiet("gabort at edge");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk_quiet($sformatf("gabort after%0d", i));
        end
        step(1'b1, 1'b1, 16'h0077, 1'b0, 1'b0, 1'b0, "gabort w");
        do_read(0, 0, 1'b0, '0, "gabort read");

        // randomized traffic against the model
        hw_reset();
        for (int n = 0; n < 400; n++) begin
            if (vld_m[raddr_m] && ($urandom_range(0, 3) == 0)) begin
                do_read(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                        1'($urandom_range(0, 1)), 16'($urandom), $sformatf("rnd%0d rd", n));
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 7) == 0), $sformatf("rnd%0d", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
